bcd_entry: RTL and testbench
============================

Name: bcd_entry

Overview:
- Front-end receiver for the operator temperature-entry protocol: the operator presses ENTER to arm, then keys three BCD digits on SW[3:0], confirming each with ENTER.
- The block debounces the raw ENTER key and steps the entry state machine.
- It assembles the 12-bit BCD reading (tens.ones.tenths) and commits it to the temperature monitor with a one-cycle strobe.
- It also drives the per-digit seven-segment enables that show entry progress.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles the synchronized key must stay stable before a level change is accepted (10 ms at 50 MHz; the bench overrides it to 8).
- BLINK_CYCLES, 12500000, half-period of the blink applied to the digit currently being entered (the bench overrides it to 4).
- TIMEOUT_CYCLES, 500000000, idle cycles inside an entry before the entry is aborted (10 s; the bench overrides it to 200).

Ports:
- CLOCK_50 in 1: system clock.
- RESET_N in 1: synchronous reset, active-low.
- KEY_ENTER_N in 1: raw ENTER push button, active-low, asynchronous to CLOCK_50.
- SW_DIGIT in 4: BCD digit switches.
- value_bcd out 12: last committed reading; [11:8] tens, [7:4] ones, [3:0] tenths.
- value_valid out 1: one-cycle strobe when value_bcd updates.
- entry_bcd out 12: partial value under entry.
- input_state out 2: 0 IDLE, 1 D0 (tenths), 2 D1 (ones), 3 D2 (tens).
- digit_en out 3: segment enables for digits 0..2.
- digit_err out 1: one-cycle strobe when a non-BCD digit is rejected.

Behaviour:
- Reset: when RESET_N=0 at a clock edge, all of the following clear:
  - outputs: value_bcd=0, entry_bcd=0, input_state=IDLE, value_valid=0, digit_err=0, digit_en=3'b111;
  - internal state: synchronizer, debounced level (released), debounce, blink and timeout counters.
- Reset dominates every other event, including a reset in the middle of an entry.
- Key conditioning:
  - KEY_ENTER_N passes through a 2-flop synchronizer.
  - The debounce counter counts while the synchronized level differs from the debounced level, and clears on any agreement.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level flips.
  - A press event is a single-cycle pulse on the released-to-pressed flip of the debounced level.
  - A held key produces exactly one press. Glitches shorter than DEBOUNCE_CYCLES produce none.
- Latency: a clean falling edge of KEY_ENTER_N at edge t is acted on (state or register update visible) at edge t+2+DEBOUNCE_CYCLES+1.
- FSM on each press:
  - IDLE: go to D0; clear entry_bcd; load the timeout counter.
  - D0: if SW_DIGIT<=9, entry_bcd[3:0]=SW_DIGIT and go to D1. Otherwise pulse digit_err and stay in D0.
  - D1: same rule into entry_bcd[7:4], then go to D2.
  - D2: same BCD check. If valid:
    - value_bcd={SW_DIGIT, entry_bcd[7:0]}, entry_bcd takes the same value, value_valid=1 for one cycle;
    - go to IDLE.
  - SW_DIGIT is sampled in the same cycle as the press pulse.
- Timeout:
  - In D0, D1 and D2 the counter decrements every cycle and reloads on every press.
  - At zero: go to IDLE, discard entry_bcd (it is restored to value_bcd), keep value_bcd, no strobe.
  - If a press and the timeout coincide, the press wins.
- Display enables:
  - IDLE: 3'b111.
  - D0: all enables off except digit 0, which blinks.
  - D1: digit 0 on, digit 1 blinks.
  - D2: digits 0 and 1 on, digit 2 blinks.
  - The blink phase toggles every BLINK_CYCLES and resets to on whenever input_state changes.
- value_valid and digit_err are never asserted in the same cycle.

Decomposition:
- Shared package (temp_pkg): input_state encodings (ST_IDLE, ST_D0, ST_D1, ST_D2), BCD_MAX=9, and the digit index constants.
- Sub-module key_debounce: synchronizer, debounce counter and press-pulse generator, parameterized by DEBOUNCE_CYCLES. The monitor's other keys reuse it.

Test Plan:
- With DEBOUNCE=8, press ENTER then enter digits 0,9,3 → input_state goes 1,2,3,0; value_bcd=12'h390; value_valid high for exactly 1 cycle; press latency is exactly 11 cycles.
- Sequence 0,0,5 (value 50.0) followed by 0,7,0 → value_bcd goes 12'h500, then 12'h070; entry_bcd is cleared at each arming press.
- In D1, set SW_DIGIT=4'hA and press → digit_err pulses once, input_state stays 2, entry_bcd unchanged; a following 2,4 completes value 12'h420.
- Hold KEY_ENTER_N low for 100 cycles in IDLE → exactly one press (state goes to D0). A 5-cycle low glitch → no state change.
- Arm, enter one digit, then wait TIMEOUT+5 cycles → input_state returns to 0, value_bcd keeps its prior 12'h420, no value_valid.
- Assert RESET_N=0 for 1 cycle while in D2 → all outputs reach their reset values on the next edge; a subsequent full entry of 12'h470 succeeds.

Source files
------------

// File: rtl/temp_pkg.sv
// Shared definitions for the temperature-entry front end: entry-state
// encodings, BCD limits and seven-segment digit positions.
package temp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_D0   = 2'd1;
  localparam logic [1:0] ST_D1   = 2'd2;
  localparam logic [1:0] ST_D2   = 2'd3;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam int unsigned DIG_TENTHS = 0;
  localparam int unsigned DIG_ONES   = 1;
  localparam int unsigned DIG_TENS   = 2;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low push-button conditioner: 2-flop synchronizer, stability
// counter and a single-cycle pulse on each accepted press.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Level flips only after the synchronized key has disagreed for a full count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_entry.sv
// Operator temperature entry: arm with ENTER, key tenths/ones/tens digits,
// commit the 12-bit BCD reading with a one-cycle strobe.
module bcd_entry
  import temp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BLINK_CYCLES    = 12500000,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        KEY_ENTER_N,
  input  logic [3:0]  SW_DIGIT,
  output logic [11:0] value_bcd,
  output logic        value_valid,
  output logic [11:0] entry_bcd,
  output logic [1:0]  input_state,
  output logic [2:0]  digit_en,
  output logic        digit_err
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic          press;
  logic [TW-1:0] tmo_cnt, tmo_cnt_d;
  logic [BW-1:0] blink_cnt, blink_cnt_d;
  logic          blink_on, blink_on_d;
  logic [1:0]    state_d;
  logic [11:0]   value_d, entry_d;
  logic          valid_d, err_d;
  logic [2:0]    en_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .key_n (KEY_ENTER_N),
    .press (press)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      input_state <= ST_IDLE;
      value_bcd   <= '0;
      entry_bcd   <= '0;
      value_valid <= 1'b0;
      digit_err   <= 1'b0;
      digit_en    <= 3'b111;
      tmo_cnt     <= '0;
      blink_cnt   <= '0;
      blink_on    <= 1'b1;
    end else begin
      input_state <= state_d;
      value_bcd   <= value_d;
      entry_bcd   <= entry_d;
      value_valid <= valid_d;
      digit_err   <= err_d;
      digit_en    <= en_d;
      tmo_cnt     <= tmo_cnt_d;
      blink_cnt   <= blink_cnt_d;
      blink_on    <= blink_on_d;
    end
  end

  always_comb begin
    state_d     = input_state;
    value_d     = value_bcd;
    entry_d     = entry_bcd;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    tmo_cnt_d   = tmo_cnt;
    blink_cnt_d = blink_cnt;
    blink_on_d  = blink_on;
    en_d        = 3'b111;

    // A press takes priority over an expiring timeout.
    if (press) begin
      tmo_cnt_d = TW'(TIMEOUT_CYCLES - 1);
      case (input_state)
        ST_IDLE: begin
          state_d = ST_D0;
          entry_d = '0;
        end
        ST_D0: begin
          if (is_bcd(SW_DIGIT)) begin
            entry_d[3:0] = SW_DIGIT;
            state_d      = ST_D1;
          end else begin
            err_d = 1'b1;
          end
        end
        ST_D1: begin
          if (is_bcd(SW_DIGIT)) begin
            entry_d[7:4] = SW_DIGIT;
            state_d      = ST_D2;
          end else begin
            err_d = 1'b1;
          end
        end
        default: begin
          if (is_bcd(SW_DIGIT)) begin
            value_d = {SW_DIGIT, entry_bcd[7:0]};
            entry_d = {SW_DIGIT, entry_bcd[7:0]};
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end else if (input_state != ST_IDLE) begin
      if (tmo_cnt == '0) begin
        state_d = ST_IDLE;
        entry_d = value_bcd;
      end else begin
        tmo_cnt_d = tmo_cnt - TW'(1);
      end
    end

    // Blink phase restarts "on" whenever the entry state moves.
    if (state_d != input_state) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on;
    end else begin
      blink_cnt_d = blink_cnt + BW'(1);
    end

    case (state_d)
      ST_IDLE: en_d = 3'b111;
      ST_D0: begin
        en_d             = 3'b000;
        en_d[DIG_TENTHS] = blink_on_d;
      end
      ST_D1: begin
        en_d             = 3'b000;
        en_d[DIG_TENTHS] = 1'b1;
        en_d[DIG_ONES]   = blink_on_d;
      end
      default: begin
        en_d             = 3'b000;
        en_d[DIG_TENTHS] = 1'b1;
        en_d[DIG_ONES]   = 1'b1;
        en_d[DIG_TENS]   = blink_on_d;
      end
    endcase
  end

endmodule

// File: tb/tb_bcd_entry.sv
// Directed bench for bcd_entry with short debounce/blink/timeout settings.
module tb_bcd_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_n = 1'b1;
  logic [3:0]  sw = 4'd0;
  logic [11:0] value_bcd;
  logic        value_valid;
  logic [11:0] entry_bcd;
  logic [1:0]  input_state;
  logic [2:0]  digit_en;
  logic        digit_err;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  bcd_entry #(
    .DEBOUNCE_CYCLES(8),
    .BLINK_CYCLES   (4),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .CLOCK_50    (clk),
    .RESET_N     (rst_n),
    .KEY_ENTER_N (key_n),
    .SW_DIGIT    (sw),
    .value_bcd   (value_bcd),
    .value_valid (value_valid),
    .entry_bcd   (entry_bcd),
    .input_state (input_state),
    .digit_en    (digit_en),
    .digit_err   (digit_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (value_valid) valid_cnt++;
    if (digit_err) err_cnt++;
    if (value_valid && digit_err) both_cnt++;
  end

  task automatic press(input logic [3:0] d);
    sw    = d;
    key_n = 1'b0;
    repeat (20) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (value_bcd !== 12'h000) begin errors++; $display("FAIL reset_value got %h exp 000", value_bcd); end
    checks++; if (entry_bcd !== 12'h000) begin errors++; $display("FAIL reset_entry got %h exp 000", entry_bcd); end
    checks++; if (input_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", input_state); end
    checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", value_valid); end
    checks++; if (digit_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", digit_err); end
    checks++; if (digit_en !== 3'b111) begin errors++; $display("FAIL reset_en got %b exp 111", digit_en); end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_basic_entry();
    int lat;
    int v0;
    logic saw0, saw1, bad;
    lat = -1;
    sw = 4'd0;
    key_n = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (input_state != 2'd0) begin
        lat = k - 1;
        break;
      end
    end
    checks++; if (lat !== 11) begin errors++; $display("FAIL press_latency got %0d exp 11", lat); end
    checks++; if (input_state !== 2'd1) begin errors++; $display("FAIL arm_state got %0d exp 1", input_state); end
    checks++; if (digit_en !== 3'b001) begin errors++; $display("FAIL arm_en got %b exp 001", digit_en); end
    repeat (10) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    v0 = valid_cnt;
    press(4'd0);
    checks++; if (input_state !== 2'd2) begin errors++; $display("FAIL d0_state got %0d exp 2", input_state); end
    saw0 = 1'b0; saw1 = 1'b0; bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (digit_en[1]) saw1 = 1'b1; else saw0 = 1'b1;
      if (digit_en[0] !== 1'b1 || digit_en[2] !== 1'b0) bad = 1'b1;
    end
    checks++; if ({saw0, saw1, bad} !== 3'b110) begin errors++; $display("FAIL d1_blink got saw0=%b saw1=%b bad=%b exp 1 1 0", saw0, saw1, bad); end
    press(4'd9);
    checks++; if (input_state !== 2'd3) begin errors++; $display("FAIL d1_state got %0d exp 3", input_state); end
    checks++; if (entry_bcd !== 12'h090) begin errors++; $display("FAIL d1_entry got %h exp 090", entry_bcd); end
    checks++; if (digit_en[1:0] !== 2'b11) begin errors++; $display("FAIL d2_en got %b exp x11", digit_en); end
    press(4'd3);
    checks++; if (input_state !== 2'd0) begin errors++; $display("FAIL d2_state got %0d exp 0", input_state); end
    checks++; if (value_bcd !== 12'h390) begin errors++; $display("FAIL value_390 got %h exp 390", value_bcd); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL valid_pulses got %0d exp 1", valid_cnt - v0); end
    checks++; if (digit_en !== 3'b111) begin errors++; $display("FAIL idle_en got %b exp 111", digit_en); end
  endtask

  task automatic test_back_to_back();
    press(4'd0);
    checks++; if (entry_bcd !== 12'h000) begin errors++; $display("FAIL arm_clear1 got %h exp 000", entry_bcd); end
    press(4'd0);
    press(4'd0);
    press(4'd5);
    checks++; if (value_bcd !== 12'h500) begin errors++; $display("FAIL value_500 got %h exp 500", value_bcd); end
    press(4'd0);
    checks++; if (entry_bcd !== 12'h000) begin errors++; $display("FAIL arm_clear2 got %h exp 000", entry_bcd); end
    press(4'd0);
    press(4'd7);
    press(4'd0);
    checks++; if (value_bcd !== 12'h070) begin errors++; $display("FAIL value_070 got %h exp 070", value_bcd); end
    checks++; if (entry_bcd !== 12'h070) begin errors++; $display("FAIL entry_070 got %h exp 070", entry_bcd); end
  endtask

  task automatic test_bad_digit();
    int e0;
    press(4'd0);
    press(4'd0);
    e0 = err_cnt;
    press(4'hA);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL err_pulses got %0d exp 1", err_cnt - e0); end
    checks++; if (input_state !== 2'd2) begin errors++; $display("FAIL err_state got %0d exp 2", input_state); end
    checks++; if (entry_bcd !== 12'h000) begin errors++; $display("FAIL err_entry got %h exp 000", entry_bcd); end
    press(4'd2);
    press(4'd4);
    checks++; if (value_bcd !== 12'h420) begin errors++; $display("FAIL value_420 got %h exp 420", value_bcd); end
  endtask

  task automatic test_hold_glitch();
    int e0;
    e0 = err_cnt;
    sw = 4'hF;
    key_n = 1'b0;
    repeat (100) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (input_state !== 2'd1) begin errors++; $display("FAIL hold_state got %0d exp 1", input_state); end
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL hold_extra_press got %0d exp 0", err_cnt - e0); end
    repeat (220) @(posedge clk);
    #1;
    checks++; if (input_state !== 2'd0) begin errors++; $display("FAIL hold_timeout got %0d exp 0", input_state); end
    key_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++; if (input_state !== 2'd0) begin errors++; $display("FAIL glitch_state got %0d exp 0", input_state); end
  endtask

  task automatic test_timeout();
    int v0;
    press(4'd0);
    press(4'd1);
    v0 = valid_cnt;
    repeat (150) @(posedge clk);
    #1;
    checks++; if (input_state !== 2'd2) begin errors++; $display("FAIL pre_timeout got %0d exp 2", input_state); end
    repeat (30) @(posedge clk);
    #1;
    checks++; if (input_state !== 2'd0) begin errors++; $display("FAIL timeout_state got %0d exp 0", input_state); end
    checks++; if (value_bcd !== 12'h420) begin errors++; $display("FAIL timeout_value got %h exp 420", value_bcd); end
    checks++; if (entry_bcd !== 12'h420) begin errors++; $display("FAIL timeout_entry got %h exp 420", entry_bcd); end
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL timeout_valid got %0d exp 0", valid_cnt - v0); end
  endtask

  task automatic test_mid_reset();
    press(4'd0);
    press(4'd0);
    press(4'd7);
    checks++; if (input_state !== 2'd3) begin errors++; $display("FAIL pre_reset_state got %0d exp 3", input_state); end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if ({value_bcd, entry_bcd} !== 24'h0) begin errors++; $display("FAIL midrst_regs got %h/%h exp 000/000", value_bcd, entry_bcd); end
    checks++; if (input_state !== 2'd0) begin errors++; $display("FAIL midrst_state got %0d exp 0", input_state); end
    checks++; if (digit_en !== 3'b111) begin errors++; $display("FAIL midrst_en got %b exp 111", digit_en); end
    checks++; if ({value_valid, digit_err} !== 2'b00) begin errors++; $display("FAIL midrst_strobes got %b exp 00", {value_valid, digit_err}); end
    repeat (3) @(posedge clk);
    #1;
    press(4'd0);
    press(4'd0);
    press(4'd7);
    press(4'd4);
    checks++; if (value_bcd !== 12'h470) begin errors++; $display("FAIL value_470 got %h exp 470", value_bcd); end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL strobe_overlap got %0d exp 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic_entry();
    test_back_to_back();
    test_bad_digit();
    test_hold_glitch();
    test_timeout();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
